sync_fifo: RTL and testbench

Single-clock, parametrised FIFO: the next generation of the team's FIFO family for paths where producer and consumer share one clock, so no pointer synchronisers are needed. It adds an occupancy count, programmable almost-full and almost-empty flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between same-clock pipeline stages and presents the `winc`/`wfull` and `rinc`/`rempty` handshake used by the rest of the FIFO family.

---
 rtl/sync_fifo.sv | 116 +++++++++++
 tb/tb_sync_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost flags and optional FWFT read.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags with err_clr.
module sync_fifo #(
   parameter int unsigned DATA_SIZE     = 8,
   parameter int unsigned ADDR_SIZE     = 4,
   parameter int unsigned AFULL_THRESH  = 12,
   parameter int unsigned AEMPTY_THRESH = 2,
   parameter int unsigned FWFT          = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 winc,
   input  logic [DATA_SIZE-1:0] wdata,
   output logic                 wfull,
   output logic                 walmost_full,
   input  logic                 rinc,
   output logic [DATA_SIZE-1:0] rdata,
   output logic                 rempty,
   output logic                 ralmost_empty,
`ifdef SYNC_FIFO_ERR_EN
   output logic                 overflow,
   output logic                 underflow,
   input  logic                 err_clr,
`endif
   output logic [ADDR_SIZE:0]   count
);

   localparam int unsigned DEPTH = 1 << ADDR_SIZE;
   localparam int unsigned CW    = ADDR_SIZE + 1;

   logic [DATA_SIZE-1:0] r_mem [DEPTH];
   logic [CW-1:0]        r_wptr;
   logic [CW-1:0]        r_rptr;
   logic [CW-1:0]        r_count;
   logic                 r_wfull;
   logic                 r_walmost_full;
   logic                 r_rempty;
   logic                 r_ralmost_empty;

   logic                 w_wr_en;
   logic                 w_rd_en;
   logic [CW-1:0]        w_count_nxt;

   // Full/empty come from the registered count, never from pointer MSBs.
   always_comb begin
      w_wr_en     = winc && !r_wfull;
      w_rd_en     = rinc && !r_rempty;
      w_count_nxt = r_count + CW'(w_wr_en) - CW'(w_rd_en);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr          <= '0;
         r_rptr          <= '0;
         r_count         <= '0;
         r_wfull         <= 1'b0;
         r_walmost_full  <= 1'b0;
         r_rempty        <= 1'b1;
         r_ralmost_empty <= 1'b1;
      end else begin
         if (w_wr_en) r_wptr <= r_wptr + CW'(1);
         if (w_rd_en) r_rptr <= r_rptr + CW'(1);
         r_count         <= w_count_nxt;
         r_wfull         <= (w_count_nxt == CW'(DEPTH));
         r_walmost_full  <= (w_count_nxt >= CW'(AFULL_THRESH));
         r_rempty        <= (w_count_nxt == CW'(0));
         r_ralmost_empty <= (w_count_nxt <= CW'(AEMPTY_THRESH));
      end
   end

   // Storage is deliberately not reset; writes in a reset cycle are dropped.
   always_ff @(posedge clk) begin
      if (rst_n && w_wr_en) r_mem[r_wptr[ADDR_SIZE-1:0]] <= wdata;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rdata = r_mem[r_rptr[ADDR_SIZE-1:0]];
      end else begin : g_std
         logic [DATA_SIZE-1:0] r_rdata;
         always_ff @(posedge clk) begin
            if (!rst_n)       r_rdata <= '0;
            else if (w_rd_en) r_rdata <= r_mem[r_rptr[ADDR_SIZE-1:0]];
         end
         assign rdata = r_rdata;
      end
   endgenerate

`ifdef SYNC_FIFO_ERR_EN
   logic r_overflow;
   logic r_underflow;

   // A set event in the same cycle as err_clr wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (winc && r_wfull)      r_overflow  <= 1'b1;
         else if (err_clr)         r_overflow  <= 1'b0;
         if (rinc && r_rempty)     r_underflow <= 1'b1;
         else if (err_clr)         r_underflow <= 1'b0;
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`endif

   assign count         = r_count;
   assign wfull         = r_wfull;
   assign walmost_full  = r_walmost_full;
   assign rempty        = r_rempty;
   assign ralmost_empty = r_ralmost_empty;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised bench for sync_fifo: standard and FWFT instances share stimulus and a queue-based model.
module tb_sync_fifo;

   localparam int unsigned DW     = 8;
   localparam int unsigned AW     = 4;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned AFULL  = 12;
   localparam int unsigned AEMPTY = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          winc;
   logic [DW-1:0] wdata;
   logic          rinc;

   logic          s_wfull, s_wafull, s_rempty, s_raempty;
   logic [DW-1:0] s_rdata;
   logic [AW:0]   s_count;
   logic          f_wfull, f_wafull, f_rempty, f_raempty;
   logic [DW-1:0] f_rdata;
   logic [AW:0]   f_count;
`ifdef SYNC_FIFO_ERR_EN
   logic          err_clr;
   logic          s_ovf, s_unf, f_ovf, f_unf;
   bit            m_ovf, m_unf;
`endif

   always #5 clk = ~clk;

   sync_fifo #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .AFULL_THRESH(AFULL),
               .AEMPTY_THRESH(AEMPTY), .FWFT(0)) u_std (
      .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata),
      .wfull(s_wfull), .walmost_full(s_wafull), .rinc(rinc), .rdata(s_rdata),
      .rempty(s_rempty), .ralmost_empty(s_raempty),
`ifdef SYNC_FIFO_ERR_EN
      .overflow(s_ovf), .underflow(s_unf), .err_clr(err_clr),
`endif
      .count(s_count));

   sync_fifo #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .AFULL_THRESH(AFULL),
               .AEMPTY_THRESH(AEMPTY), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata),
      .wfull(f_wfull), .walmost_full(f_wafull), .rinc(rinc), .rdata(f_rdata),
      .rempty(f_rempty), .ralmost_empty(f_raempty),
`ifdef SYNC_FIFO_ERR_EN
      .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr),
`endif
      .count(f_count));

   int unsigned n_checks   = 0;
   int unsigned n_failures = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] m_rdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge: drive, advance the model by the FIFO rules, then compare.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit rst);
      bit wr_ok, rd_ok;
      int unsigned sz;
      winc  = w;
      wdata = d;
      rinc  = r;
      rst_n = ~rst;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_rdata = '0;
`ifdef SYNC_FIFO_ERR_EN
         m_ovf = 0;
         m_unf = 0;
`endif
      end else begin
         sz    = q.size();
         wr_ok = w && (sz < DEPTH);
         rd_ok = r && (sz > 0);
`ifdef SYNC_FIFO_ERR_EN
         if (w && sz == DEPTH) m_ovf = 1; else if (err_clr) m_ovf = 0;
         if (r && sz == 0)     m_unf = 1; else if (err_clr) m_unf = 0;
`endif
         if (rd_ok) m_rdata = q.pop_front();
         if (wr_ok) q.push_back(d);
      end
      #1;
      sz = q.size();
      check("count",      32'(s_count),   sz);
      check("wfull",      32'(s_wfull),   32'(sz == DEPTH));
      check("walmost",    32'(s_wafull),  32'(sz >= AFULL));
      check("rempty",     32'(s_rempty),  32'(sz == 0));
      check("ralmost",    32'(s_raempty), 32'(sz <= AEMPTY));
      check("rdata_std",  32'(s_rdata),   32'(m_rdata));
      check("count_fwft", 32'(f_count),   sz);
      check("rempty_fwft",32'(f_rempty),  32'(sz == 0));
      check("wfull_fwft", 32'(f_wfull),   32'(sz == DEPTH));
      if (sz > 0) check("rdata_fwft", 32'(f_rdata), 32'(q[0]));
`ifdef SYNC_FIFO_ERR_EN
      check("overflow",  32'(s_ovf), 32'(m_ovf));
      check("underflow", 32'(s_unf), 32'(m_unf));
      check("ovf_fwft",  32'(f_ovf), 32'(m_ovf));
      check("unf_fwft",  32'(f_unf), 32'(m_unf));
`endif
   endtask

   initial begin
      int unsigned wp, rp;
      winc = 0; rinc = 0; wdata = '0; rst_n = 0;
`ifdef SYNC_FIFO_ERR_EN
      err_clr = 0;
`endif
      // Reset with requests present: they must be ignored.
      step(1, 8'hEE, 1, 1);
      step(0, 8'h00, 0, 1);
      check("rst_count", 32'(s_count), 0);
      check("rst_rempty", 32'(s_rempty), 1);

      // Fill with 0x01..0x10, then one rejected write.
      for (int i = 1; i <= 16; i++) begin
         step(1, DW'(i), 0, 0);
         if (i == 12) check("afull_at_12", 32'(s_wafull), 1);
         if (i == 11) check("afull_at_11", 32'(s_wafull), 0);
      end
      check("full_flag", 32'(s_wfull), 1);
      step(1, 8'hFF, 0, 0);
      check("full_count", 32'(s_count), 16);

      // Drain in standard mode, plus one extra read.
      for (int i = 1; i <= 16; i++) begin
         step(0, 8'h00, 1, 0);
         check("drain_data", 32'(s_rdata), 32'(i));
      end
      step(0, 8'h00, 1, 0);
      check("hold_data", 32'(s_rdata), 32'h10);
`ifdef SYNC_FIFO_ERR_EN
      err_clr = 1;
      step(0, 8'h00, 0, 0);
      err_clr = 0;
`endif

      // Steady state at count 5 with both strobes every cycle for 40 cycles.
      for (int i = 0; i < 5; i++) step(1, DW'(8'h20 + i), 0, 0);
      for (int i = 0; i < 40; i++) step(1, DW'(8'h40 + i), 1, 0);
      check("steady_count", 32'(s_count), 5);
      for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);

      // FWFT: data visible the cycle after the write, no rinc needed.
      step(1, 8'hA5, 0, 0);
      check("fwft_a5", 32'(f_rdata), 32'hA5);
      check("fwft_nonempty", 32'(f_rempty), 0);
      step(0, 8'h00, 1, 0);
      check("fwft_empty", 32'(f_rempty), 1);

      // Full with both strobes: read wins, write rejected.
      for (int i = 0; i < 16; i++) step(1, DW'(8'h60 + i), 0, 0);
      step(1, 8'h99, 1, 0);
      check("full_rw_count", 32'(s_count), 15);
      for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0);

      // Reset at count 7, then only new data comes out.
      for (int i = 0; i < 7; i++) step(1, DW'(8'h70 + i), 0, 0);
      step(1, 8'h55, 1, 1);
      check("mid_rst_count", 32'(s_count), 0);
      check("mid_rst_rdata", 32'(s_rdata), 0);
      step(1, 8'hC3, 0, 0);
      step(0, 8'h00, 1, 0);
      check("post_rst_data", 32'(s_rdata), 32'hC3);

      // Random phases with varying write/read bias and occasional reset.
      for (int blk = 0; blk < 20; blk++) begin
         wp = $urandom_range(10, 90);
         rp = $urandom_range(10, 90);
         for (int i = 0; i < 150; i++) begin
`ifdef SYNC_FIFO_ERR_EN
            err_clr = ($urandom_range(0, 19) == 0);
`endif
            step($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < rp,
                 $urandom_range(0, 299) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule
